// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 read-channel arbiter; grant held from AR through the rlast beat.
// Define ARB_RR_EN for round-robin priority; the default build gives the LSU fixed priority.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read master
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [ID_W-1:0]   ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic [ID_W-1:0]   ifu_rid,
  // LSU read master
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [ID_W-1:0]   lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic [ID_W-1:0]   lsu_rid,
  // downstream memory port
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   pick;

`ifdef ARB_RR_EN
  logic   last_gnt_q, last_gnt_d;

  // On contention the master that did not win last time goes first.
  always_comb begin
    if (ifu_arvalid && lsu_arvalid) pick = ~last_gnt_q;
    else                            pick = lsu_arvalid ? GNT_LSU : GNT_IFU;
  end
`else
  always_comb pick = lsu_arvalid ? GNT_LSU : GNT_IFU;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= GNT_IFU;
`ifdef ARB_RR_EN
      last_gnt_q <= GNT_IFU;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
`ifdef ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  // Next-state: grant latched in IDLE, held until the rlast beat handshakes.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
`ifdef ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d    = S_ADDR;
          gnt_d      = pick;
`ifdef ARB_RR_EN
          last_gnt_d = pick;
`endif
        end
      end
      S_ADDR: if (m_arvalid && m_arready) state_d = S_DATA;
      S_DATA: if (m_rvalid && m_rready && m_rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel steering; everything not owned by the granted master is held at zero.
  always_comb begin
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    unique case (state_q)
      S_ADDR: begin
        if (gnt_q == GNT_LSU) begin
          m_arvalid   = lsu_arvalid;
          m_araddr    = lsu_araddr;
          m_arid      = lsu_arid;
          m_arlen     = lsu_arlen;
          m_arsize    = lsu_arsize;
          m_arburst   = lsu_arburst;
          lsu_arready = m_arready;
        end else begin
          m_arvalid   = ifu_arvalid;
          m_araddr    = ifu_araddr;
          m_arid      = ifu_arid;
          m_arlen     = ifu_arlen;
          m_arsize    = ifu_arsize;
          m_arburst   = ifu_arburst;
          ifu_arready = m_arready;
        end
      end
      S_DATA: begin
        if (gnt_q == GNT_LSU) begin
          m_rready   = lsu_rready;
          lsu_rvalid = m_rvalid;
          lsu_rdata  = m_rdata;
          lsu_rresp  = m_rresp;
          lsu_rlast  = m_rlast;
          lsu_rid    = m_rid;
        end else begin
          m_rready   = ifu_rready;
          ifu_rvalid = m_rvalid;
          ifu_rdata  = m_rdata;
          ifu_rresp  = m_rresp;
          ifu_rlast  = m_rlast;
          ifu_rid    = m_rid;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter; define ARB_RR_EN here too when building the round-robin variant.
module tb_axi_rd_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned NTXN    = 60;
  localparam int unsigned MAX_CYC = 30000;

  typedef struct {
    logic              m;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int unsigned       dec_cyc;
  } ar_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // master-side stimulus, index 0 = IFU, 1 = LSU
  logic              av   [2];
  logic [ADDR_W-1:0] aa   [2];
  logic [ID_W-1:0]   aid  [2];
  logic [7:0]        alen [2];
  logic [2:0]        asz  [2];
  logic [1:0]        abu  [2];
  logic              rr   [2];

  logic              s_arready, s_rvalid, s_rlast;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic [ID_W-1:0]   s_rid;

  logic              ifu_arready, ifu_rvalid, ifu_rlast;
  logic [DATA_W-1:0] ifu_rdata;
  logic [1:0]        ifu_rresp;
  logic [ID_W-1:0]   ifu_rid;
  logic              lsu_arready, lsu_rvalid, lsu_rlast;
  logic [DATA_W-1:0] lsu_rdata;
  logic [1:0]        lsu_rresp;
  logic [ID_W-1:0]   lsu_rid;
  logic              m_arvalid, m_rready, busy;
  logic [ADDR_W-1:0] m_araddr;
  logic [ID_W-1:0]   m_arid;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(av[0]), .ifu_arready(ifu_arready), .ifu_araddr(aa[0]), .ifu_arid(aid[0]),
    .ifu_arlen(alen[0]), .ifu_arsize(asz[0]), .ifu_arburst(abu[0]),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(rr[0]), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(av[1]), .lsu_arready(lsu_arready), .lsu_araddr(aa[1]), .lsu_arid(aid[1]),
    .lsu_arlen(alen[1]), .lsu_arsize(asz[1]), .lsu_arburst(abu[1]),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(rr[1]), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .m_arvalid(m_arvalid), .m_arready(s_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(s_rvalid), .m_rready(m_rready), .m_rdata(s_rdata), .m_rresp(s_rresp),
    .m_rlast(s_rlast), .m_rid(s_rid),
    .busy(busy)
  );

  ar_t   ar_q[$];
  beat_t ifu_bq[$];
  beat_t lsu_bq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  exp_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave read data is a fixed function of address and beat index.
  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
    return DATA_W'(a) ^ DATA_W'(32'h9e37_79b9 * (b + 1));
  endfunction

  function automatic logic any_out();
    return |{m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
             ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rid,
             lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rlast, lsu_rid, busy};
  endfunction

  // ---------------- stimulus + reference model ----------------
  initial begin
    logic        req [2];
    logic        ar_hs [2];
    logic        r_end, m_ar_hs, m_r_hs, model_idle, last_gnt, w, did_rst, fin;
    logic [ADDR_W-1:0] sa, s_addr;
    logic [ID_W-1:0]   sid, s_id;
    logic [7:0]        slen, s_len;
    int          s_beat, issued [2];
    logic        s_busy;
    ar_t         e;
    beat_t       bt;

    for (int m = 0; m < 2; m++) begin
      av[m] = 1'b0; aa[m] = '0; aid[m] = '0; alen[m] = '0; asz[m] = '0; abu[m] = '0;
      rr[m] = 1'b0; issued[m] = 0;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    s_busy = 1'b0; s_addr = '0; s_id = '0; s_len = '0; s_beat = 0;
    model_idle = 1'b1; last_gnt = 1'b0; did_rst = 1'b0; fin = 1'b0;

    repeat (3) @(posedge clk);
    #2 chk("reset_outputs_zero", 64'(any_out()), 64'(0));
    rst = 1'b1;

    while (!fin) begin
      @(negedge clk);
      req[0] = av[0];  req[1] = av[1];
      ar_hs[0] = av[0] & ifu_arready;
      ar_hs[1] = av[1] & lsu_arready;
      r_end   = (ifu_rvalid & rr[0] & ifu_rlast) | (lsu_rvalid & rr[1] & lsu_rlast);
      m_ar_hs = m_arvalid & s_arready;
      m_r_hs  = s_rvalid & m_rready;
      sa = m_araddr; sid = m_arid; slen = m_arlen;
      @(posedge clk);
      #1;

      // arbitration decision taken at the edge just passed
      if (model_idle && (req[0] || req[1])) begin
`ifdef ARB_RR_EN
        w = (req[0] && req[1]) ? ~last_gnt : req[1];
        last_gnt = w;
`else
        w = req[1];
`endif
        e.m = w; e.addr = aa[w]; e.id = aid[w]; e.len = alen[w]; e.size = asz[w];
        e.burst = abu[w]; e.dec_cyc = cyc;
        ar_q.push_back(e);
        for (int b = 0; b <= int'(alen[w]); b++) begin
          bt.data = beat_data(aa[w], b);
          bt.resp = aa[w][3:2];
          bt.last = (b == int'(alen[w]));
          bt.id   = aid[w];
          if (w) lsu_bq.push_back(bt);
          else   ifu_bq.push_back(bt);
        end
        model_idle = 1'b0;
      end else if (r_end) begin
        model_idle = 1'b1;
      end
      exp_busy = ~model_idle;

      // masters: hold arvalid until accepted, random rready
      for (int m = 0; m < 2; m++) begin
        if (ar_hs[m]) av[m] = 1'b0;
        if (!av[m] && issued[m] < int'(NTXN) && $urandom_range(0, 3) == 0) begin
          av[m]   = 1'b1;
          aa[m]   = ADDR_W'($urandom);
          aid[m]  = ID_W'($urandom);
          alen[m] = 8'($urandom_range(0, 3));
          asz[m]  = 3'($urandom);
          abu[m]  = 2'($urandom);
          issued[m]++;
        end
        rr[m] = ($urandom_range(0, 3) != 0);
      end

      // slave: one burst at a time, random arready and rvalid gaps
      if (m_ar_hs) begin
        s_busy = 1'b1; s_addr = sa; s_id = sid; s_len = slen; s_beat = 0;
      end
      if (m_r_hs) begin
        if (s_beat == int'(s_len)) s_busy = 1'b0;
        s_beat++;
        s_rvalid = 1'b0;
      end
      if (s_busy && !s_rvalid && $urandom_range(0, 2) != 0) begin
        s_rvalid = 1'b1;
        s_rdata  = beat_data(s_addr, s_beat);
        s_rresp  = s_addr[3:2];
        s_rlast  = (s_beat == int'(s_len));
        s_rid    = s_id;
      end
      s_arready = !s_busy && ($urandom_range(0, 1) == 1);

      // one asynchronous reset in the middle of a data phase
      if (!did_rst && cyc >= 500 && s_busy) begin
        did_rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs_zero", 64'(any_out()), 64'(0));
        for (int m = 0; m < 2; m++) av[m] = 1'b0;
        s_busy = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0; s_rlast = 1'b0;
        model_idle = 1'b1; last_gnt = 1'b0; exp_busy = 1'b0;
        ar_q.delete(); ifu_bq.delete(); lsu_bq.delete();
        @(posedge clk);
        #3 rst = 1'b1;
      end

      fin = (cyc >= MAX_CYC) ||
            (issued[0] == int'(NTXN) && issued[1] == int'(NTXN) && !av[0] && !av[1] &&
             model_idle && ar_q.size() == 0 && ifu_bq.size() == 0 && lsu_bq.size() == 0);
    end

    repeat (2) @(posedge clk);
    chk("timeout", 64'(cyc >= MAX_CYC), 64'(0));
    chk("ar_left", 64'(ar_q.size()), 64'(0));
    chk("beats_left", 64'(ifu_bq.size() + lsu_bq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  ar_t  cur;
  logic cur_v    = 1'b0;
  logic prev_arv = 1'b0;

  task automatic check_r(input logic m, input logic rv, input logic rdy,
                         input logic [DATA_W-1:0] d, input logic [1:0] rs,
                         input logic l, input logic [ID_W-1:0] id);
    beat_t e;
    string p;
    int    n;
    p = m ? "lsu" : "ifu";
    if (!rv) return;
    n = m ? lsu_bq.size() : ifu_bq.size();
    if (n == 0) begin
      chk({p, "_unexpected_rvalid"}, 64'(1), 64'(0));
      return;
    end
    e = m ? lsu_bq[0] : ifu_bq[0];
    chk({p, "_rdata"}, 64'(d), 64'(e.data));
    chk({p, "_rresp"}, 64'(rs), 64'(e.resp));
    chk({p, "_rlast"}, 64'(l), 64'(e.last));
    chk({p, "_rid"}, 64'(id), 64'(e.id));
    chk({p, "_m_rready"}, 64'(m_rready), 64'(rdy));
    if (rdy) begin
      if (m) e = lsu_bq.pop_front();
      else   e = ifu_bq.pop_front();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_v = 1'b0; prev_arv = 1'b0;
      end else begin
        chk("busy", 64'(busy), 64'(exp_busy));

        // AR forwarding: must appear the cycle after the decision, from the winner
        if (m_arvalid && !prev_arv) begin
          if (ar_q.size() == 0) chk("unexpected_m_arvalid", 64'(1), 64'(0));
          else begin
            cur = ar_q.pop_front();
            cur_v = 1'b1;
            chk("ar_latency", 64'(cyc), 64'(cur.dec_cyc));
          end
        end
        while (ar_q.size() > 0 && cyc > ar_q[0].dec_cyc) begin
          chk("ar_missing", 64'(0), 64'(1));
          cur = ar_q.pop_front();
          cur_v = 1'b0;
        end
        if (m_arvalid && cur_v) begin
          chk("m_araddr", 64'(m_araddr), 64'(cur.addr));
          chk("m_arid", 64'(m_arid), 64'(cur.id));
          chk("m_arlen", 64'(m_arlen), 64'(cur.len));
          chk("m_arsize_burst", 64'({m_arsize, m_arburst}), 64'({cur.size, cur.burst}));
          chk("arready_route", 64'({ifu_arready, lsu_arready}),
              64'(cur.m ? {1'b0, s_arready} : {s_arready, 1'b0}));
        end else if (!m_arvalid) begin
          chk("arready_idle", 64'({ifu_arready, lsu_arready}), 64'(0));
        end
        prev_arv = m_arvalid;

        // R path
        if (ifu_rvalid && lsu_rvalid) chk("both_rvalid", 64'(1), 64'(0));
        if (s_rvalid && !ifu_rvalid && !lsu_rvalid) chk("r_not_forwarded", 64'(0), 64'(1));
        check_r(1'b0, ifu_rvalid, rr[0], ifu_rdata, ifu_rresp, ifu_rlast, ifu_rid);
        check_r(1'b1, lsu_rvalid, rr[1], lsu_rdata, lsu_rresp, lsu_rlast, lsu_rid);
      end
    end
  end

endmodule
